// File: rtl/gs_line_sched_pkg.sv
// -----------------------------------------------------------------------------
// gs_line_sched_pkg
// Shared types and constants for the ping-pong line scheduler that feeds the
// 5x5 Gaussian filter.
//   state_t     : scheduler FSM states
//   GS_RAM_LAT  : line RAM read latency (cycles)
//   GS_FILT_LAT : filter pipeline latency (cycles)
//   GS_KERNEL   : filter kernel size
// -----------------------------------------------------------------------------
package gs_line_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_REL   = 3'd4
   } state_t;

   localparam int unsigned GS_RAM_LAT  = 1;
   localparam int unsigned GS_FILT_LAT = 5;
   localparam int unsigned GS_KERNEL   = 5;

endpackage

// File: rtl/gs_line_sched_if.sv
// -----------------------------------------------------------------------------
// gs_line_sched_if
// Bundle between the line scheduler, the upstream line writer, the two line
// RAMs and the Gaussian filter.
//   wr_done0/1         : writer finished filling bank 0/1 (pulse)
//   rel0/1             : bank 0/1 free to be rewritten (pulse)
//   filt_start         : clear pulse to the filter
//   ram0/1_rd_en/addr  : bank read port
//   op_valid_out       : filter output valid
// Modports: slave = scheduler side, master = environment side.
// -----------------------------------------------------------------------------
interface gs_line_sched_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              wr_done0;
   logic              wr_done1;
   logic              op_valid_out;
   logic              filt_start;
   logic              ram0_rd_en;
   logic              ram1_rd_en;
   logic [ADDR_W-1:0] ram0_rd_addr;
   logic [ADDR_W-1:0] ram1_rd_addr;
   logic              rel0;
   logic              rel1;

   modport slave (
      input  wr_done0, wr_done1, op_valid_out,
      output filt_start, ram0_rd_en, ram1_rd_en, ram0_rd_addr, ram1_rd_addr,
             rel0, rel1
   );

   modport master (
      output wr_done0, wr_done1, op_valid_out,
      input  filt_start, ram0_rd_en, ram1_rd_en, ram0_rd_addr, ram1_rd_addr,
             rel0, rel1
   );
endinterface

// File: rtl/gs_line_sched_wdog.sv
// -----------------------------------------------------------------------------
// gs_line_sched_wdog
// DRAIN watchdog: counts cycles while enabled and flags expiry on the
// DRAIN_MAX-th enabled cycle since the last clear.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : count enable (scheduler is in DRAIN)
//   i_clr        : restart the count (start of a line)
//   o_expire     : high during the enabled cycle that completes DRAIN_MAX
// -----------------------------------------------------------------------------
module gs_line_sched_wdog #(
   parameter int unsigned DRAIN_MAX = 15
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_expire
);
   localparam int unsigned CW = $clog2(DRAIN_MAX + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != CW'(DRAIN_MAX))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // r_cnt is 0 in the first DRAIN cycle, so DRAIN_MAX-1 marks the last one.
   assign o_expire = i_en && (r_cnt == CW'(DRAIN_MAX - 1));
endmodule

// File: rtl/gs_line_sched.sv
// -----------------------------------------------------------------------------
// gs_line_sched
// Ping-pong line scheduler for the 5x5 Gaussian filter. Serves filled banks in
// strict alternation: clears the filter, reads LINE_LEN pixels from bank cur,
// waits for LINE_LEN filter outputs, then releases the bank to the writer.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   bus (slave)   : writer / RAM / filter signals, see gs_line_sched_if
//   o_busy        : FSM not in IDLE
//   o_line_done   : pulse at the end of each line
//   o_err_ovf     : sticky, wr_done on a bank that was already pending
//   o_err_to      : sticky, DRAIN watchdog expired
// Optional feature: define GS_LINE_SCHED_WDOG_EN to enable the DRAIN watchdog;
// without it o_err_to is constant 0 and DRAIN waits indefinitely.
// -----------------------------------------------------------------------------
module gs_line_sched
   import gs_line_sched_pkg::*;
#(
   parameter int unsigned LINE_LEN  = 256,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DRAIN_MAX = 15
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   gs_line_sched_if.slave        bus,
   output logic                  o_busy,
   output logic                  o_line_done,
   output logic                  o_err_ovf,
   output logic                  o_err_to
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);
   localparam logic [ADDR_W:0]   LEN_CNT   = (ADDR_W + 1)'(LINE_LEN);

   state_t            r_state;
   state_t            w_state_next;
   logic [1:0]        r_pend;
   logic              r_cur;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_ocnt;
   logic              r_err_ovf;

   logic              w_in_clr;
   logic              w_in_read;
   logic              w_in_drain;
   logic              w_in_rel;
   logic              w_cnt_done;
   logic              w_wdog_expire;
   logic [1:0]        w_wr_done;
   logic [1:0]        w_rd_en;
   logic [1:0]        w_rel;
   logic [ADDR_W-1:0] w_rd_addr [2];

   assign w_in_clr   = (r_state == ST_CLR);
   assign w_in_read  = (r_state == ST_READ);
   assign w_in_drain = (r_state == ST_DRAIN);
   assign w_in_rel   = (r_state == ST_REL);
   assign w_wr_done  = {bus.wr_done1, bus.wr_done0};

   // Includes this cycle's valid so REL follows the final output directly.
   assign w_cnt_done = (r_ocnt == LEN_CNT) ||
                       (bus.op_valid_out && (r_ocnt == LEN_CNT - 1'b1));

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (r_pend[r_cur]) w_state_next = ST_CLR;
         ST_CLR:   w_state_next = ST_READ;
         ST_READ:  if (r_addr == LAST_ADDR) w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_cnt_done || w_wdog_expire) w_state_next = ST_REL;
         ST_REL:   w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // ---------------- Bank bookkeeping and counters ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pend    <= '0;
         r_cur     <= 1'b0;
         r_addr    <= '0;
         r_ocnt    <= '0;
         r_err_ovf <= 1'b0;
      end else begin
         // Set wins over release in the same cycle.
         r_pend <= w_wr_done | (r_pend & ~w_rel);
         if (|(w_wr_done & r_pend)) r_err_ovf <= 1'b1;
         if (w_in_rel) r_cur <= ~r_cur;

         if (w_in_clr) begin
            r_addr <= '0;
         end else if (w_in_read) begin
            r_addr <= r_addr + 1'b1;
         end

         if (w_in_clr) begin
            r_ocnt <= '0;
         end else if ((w_in_read || w_in_drain) && bus.op_valid_out &&
                      (r_ocnt != LEN_CNT)) begin
            r_ocnt <= r_ocnt + 1'b1;
         end
      end
   end

   // ---------------- Per-bank outputs ----------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         assign w_rd_en[gi]   = w_in_read && (r_cur == 1'(gi));
         assign w_rel[gi]     = w_in_rel  && (r_cur == 1'(gi));
         assign w_rd_addr[gi] = w_rd_en[gi] ? r_addr : '0;
      end
   endgenerate

   assign bus.filt_start   = w_in_clr;
   assign bus.ram0_rd_en   = w_rd_en[0];
   assign bus.ram1_rd_en   = w_rd_en[1];
   assign bus.ram0_rd_addr = w_rd_addr[0];
   assign bus.ram1_rd_addr = w_rd_addr[1];
   assign bus.rel0         = w_rel[0];
   assign bus.rel1         = w_rel[1];

   assign o_busy      = (r_state != ST_IDLE);
   assign o_line_done = w_in_rel;
   assign o_err_ovf   = r_err_ovf;

   // ---------------- Optional DRAIN watchdog ----------------
`ifdef GS_LINE_SCHED_WDOG_EN
   logic r_err_to;

   gs_line_sched_wdog #(
      .DRAIN_MAX (DRAIN_MAX)
   ) u_wdog (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (w_in_drain),
      .i_clr    (w_in_clr),
      .o_expire (w_wdog_expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err_to <= 1'b0;
      end else if (w_in_drain && w_wdog_expire && !w_cnt_done) begin
         r_err_to <= 1'b1;
      end
   end

   assign o_err_to = r_err_to;
`else
   assign w_wdog_expire = 1'b0;
   assign o_err_to      = 1'b0;
`endif

endmodule

// File: tb/tb_gs_line_sched.sv
// -----------------------------------------------------------------------------
// tb_gs_line_sched
// Self-checking bench for gs_line_sched with LINE_LEN=8 and a 6-cycle
// RAM+filter model. Cycle numbers count clock edges after reset release;
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_gs_line_sched;
   import gs_line_sched_pkg::*;

   localparam int unsigned L    = 8;
   localparam int unsigned AW   = 8;
   localparam int unsigned DM   = 15;
   localparam int          PIPE = GS_RAM_LAT + GS_FILT_LAT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gs_line_sched_if #(.ADDR_W(AW)) bus ();

   logic busy, line_done, err_ovf, err_to;

   gs_line_sched #(
      .LINE_LEN  (L),
      .ADDR_W    (AW),
      .DRAIN_MAX (DM)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .bus         (bus),
      .o_busy      (busy),
      .o_line_done (line_done),
      .o_err_ovf   (err_ovf),
      .o_err_to    (err_to)
   );

   // ---------------- RAM + filter latency model ----------------
   logic [PIPE-1:0] pipe;
   logic            spur;
   int              drop_addr;
   logic            feed;

   assign feed = (bus.ram0_rd_en || bus.ram1_rd_en) &&
                 !(bus.ram0_rd_en && (int'(bus.ram0_rd_addr) == drop_addr));

   always @(posedge clk) begin
      if (rst) pipe <= '0;
      else     pipe <= {pipe[PIPE-2:0], feed};
   end

   assign bus.op_valid_out = pipe[PIPE-1] | spur;

   // ---------------- Bookkeeping ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int start_q[$];
   int rel0_q[$];
   int rel1_q[$];
   int first_rd1;
   bit overlap = 1'b0;
   bit ld_bad  = 1'b0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   // One clock: pulses set by the caller last exactly one cycle.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      bus.wr_done0 = 1'b0;
      bus.wr_done1 = 1'b0;
      spur         = 1'b0;
      if (bus.filt_start) start_q.push_back(cyc);
      if (bus.rel0) begin
         rel0_q.push_back(cyc);
         $display("cyc %0d: bank 0 released", cyc);
      end
      if (bus.rel1) begin
         rel1_q.push_back(cyc);
         $display("cyc %0d: bank 1 released", cyc);
      end
      if (bus.ram1_rd_en && first_rd1 < 0) first_rd1 = cyc;
      if (bus.filt_start && (bus.ram0_rd_en || bus.ram1_rd_en)) overlap = 1'b1;
      if (bus.ram0_rd_en && bus.ram1_rd_en) overlap = 1'b1;
      if (line_done !== (bus.rel0 | bus.rel1)) ld_bad = 1'b1;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      cyc = 0;
      start_q.delete();
      rel0_q.delete();
      rel1_q.delete();
      first_rd1 = -1;
   endtask

   // ---------------- Single-line vector table ----------------
   typedef struct {
      int   cyc;
      bit   wd0;
      bit   spur;
      bit   chk;
      bit   start;
      bit   rd0;
      int   addr0;
      bit   rel0;
      bit   busy;
   } vec_t;

   localparam int NV = 13;
   vec_t tv [NV];

   initial begin
      bus.wr_done0 = 1'b0;
      bus.wr_done1 = 1'b0;
      spur         = 1'b0;
      drop_addr    = -1;
      first_rd1    = -1;

      //           cyc wd0 spur chk start rd0 addr rel0 busy
      tv[0]  = '{  0,  0,  0,   1,  0,    0,  0,   0,   0 };
      tv[1]  = '{  4,  0,  1,   0,  0,    0,  0,   0,   0 };
      tv[2]  = '{  6,  0,  1,   0,  0,    0,  0,   0,   0 };
      tv[3]  = '{ 10,  1,  0,   0,  0,    0,  0,   0,   0 };
      tv[4]  = '{ 11,  0,  0,   1,  0,    0,  0,   0,   0 };
      tv[5]  = '{ 12,  0,  0,   1,  1,    0,  0,   0,   1 };
      tv[6]  = '{ 13,  0,  0,   1,  0,    1,  0,   0,   1 };
      tv[7]  = '{ 16,  0,  0,   1,  0,    1,  3,   0,   1 };
      tv[8]  = '{ 20,  0,  0,   1,  0,    1,  7,   0,   1 };
      tv[9]  = '{ 21,  0,  0,   1,  0,    0,  0,   0,   1 };
      tv[10] = '{ 26,  0,  0,   1,  0,    0,  0,   0,   1 };
      tv[11] = '{ 27,  0,  0,   1,  0,    0,  0,   1,   1 };
      tv[12] = '{ 28,  0,  0,   1,  0,    0,  0,   0,   0 };

      // ---- Single line with spurious valids while IDLE ----
      do_reset();
      for (int c = 0; c <= 30; c++) begin
         run_to(c);
         for (int i = 0; i < NV; i++) begin
            if (tv[i].cyc == c) begin
               if (tv[i].wd0)  bus.wr_done0 = 1'b1;
               if (tv[i].spur) spur = 1'b1;
               if (tv[i].chk) begin
                  cmp("v_start", 32'(bus.filt_start),   32'(tv[i].start));
                  cmp("v_rd0",   32'(bus.ram0_rd_en),   32'(tv[i].rd0));
                  cmp("v_addr0", 32'(bus.ram0_rd_addr), 32'(tv[i].addr0));
                  cmp("v_rd1",   32'(bus.ram1_rd_en),   32'd0);
                  cmp("v_rel0",  32'(bus.rel0),         32'(tv[i].rel0));
                  cmp("v_ld",    32'(line_done),        32'(tv[i].rel0));
                  cmp("v_busy",  32'(busy),             32'(tv[i].busy));
                  cmp("v_ovf",   32'(err_ovf),          32'd0);
                  cmp("v_to",    32'(err_to),           32'd0);
               end
            end
         end
      end
      cmp("single_rel0_cnt", 32'(rel0_q.size()), 32'd1);

      // ---- Strict ping-pong: bank 1 pending first waits for bank 0 ----
      do_reset();
      run_to(2);
      bus.wr_done1 = 1'b1;
      run_to(10);
      cmp("pp_idle_busy", 32'(busy), 32'd0);
      cmp("pp_no_start",  32'(start_q.size()), 32'd0);
      bus.wr_done0 = 1'b1;
      run_to(33);
      cmp("pp_rd1_en",   32'(bus.ram1_rd_en),   32'd1);
      cmp("pp_rd1_addr", 32'(bus.ram1_rd_addr), 32'd3);
      cmp("pp_rd0_off",  32'(bus.ram0_rd_en),   32'd0);
      run_to(50);
      cmp("pp_nstart", 32'(start_q.size()), 32'd2);
      if (start_q.size() == 2) begin
         cmp("pp_start0", 32'(start_q[0]), 32'd12);
         cmp("pp_start1", 32'(start_q[1]), 32'd29);
      end
      cmp("pp_nrel0", 32'(rel0_q.size()), 32'd1);
      if (rel0_q.size() == 1) cmp("pp_rel0", 32'(rel0_q[0]), 32'd27);
      cmp("pp_nrel1", 32'(rel1_q.size()), 32'd1);
      if (rel1_q.size() == 1) cmp("pp_rel1", 32'(rel1_q[0]), 32'd44);
      cmp("pp_first_rd1", 32'(first_rd1), 32'd30);

      // ---- Overflow, and wr_done0 coinciding with rel0 ----
      do_reset();
      run_to(2);
      bus.wr_done0 = 1'b1;
      run_to(5);
      cmp("ovf_before", 32'(err_ovf), 32'd0);
      run_to(6);
      bus.wr_done0 = 1'b1;
      run_to(7);
      cmp("ovf_set", 32'(err_ovf), 32'd1);
      run_to(8);
      bus.wr_done1 = 1'b1;
      run_to(19);
      cmp("ovf_rel0_now", 32'(bus.rel0), 32'd1);
      bus.wr_done0 = 1'b1;
      run_to(60);
      cmp("ovf_sticky", 32'(err_ovf), 32'd1);
      cmp("ovf_nstart", 32'(start_q.size()), 32'd3);
      if (start_q.size() == 3) begin
         cmp("ovf_start1", 32'(start_q[1]), 32'd21);
         cmp("ovf_start2", 32'(start_q[2]), 32'd38);
      end
      cmp("ovf_nrel0", 32'(rel0_q.size()), 32'd2);
      if (rel0_q.size() == 2) cmp("ovf_rel0_2nd", 32'(rel0_q[1]), 32'd53);
      cmp("ovf_nrel1", 32'(rel1_q.size()), 32'd1);
      if (rel1_q.size() == 1) cmp("ovf_rel1", 32'(rel1_q[0]), 32'd36);

      // ---- Reset in the middle of READ ----
      do_reset();
      run_to(2);
      bus.wr_done0 = 1'b1;
      run_to(6);
      bus.wr_done0 = 1'b1;
      run_to(8);
      cmp("rst_pre_rd0",  32'(bus.ram0_rd_en),   32'd1);
      cmp("rst_pre_addr", 32'(bus.ram0_rd_addr), 32'd3);
      cmp("rst_pre_ovf",  32'(err_ovf),          32'd1);
      rst = 1'b1;
      run_to(9);
      rst = 1'b0;
      cmp("rst_busy",  32'(busy),             32'd0);
      cmp("rst_rd0",   32'(bus.ram0_rd_en),   32'd0);
      cmp("rst_addr",  32'(bus.ram0_rd_addr), 32'd0);
      cmp("rst_start", 32'(bus.filt_start),   32'd0);
      cmp("rst_rel0",  32'(bus.rel0),         32'd0);
      cmp("rst_ovf",   32'(err_ovf),          32'd0);
      run_to(14);
      cmp("rst_idle",    32'(busy),           32'd0);
      cmp("rst_no_rel",  32'(rel0_q.size()),  32'd0);
      run_to(20);
      bus.wr_done0 = 1'b1;
      run_to(22);
      cmp("rst_restart", 32'(bus.filt_start), 32'd1);
      run_to(23);
      cmp("rst_rd0_again", 32'(bus.ram0_rd_en),   32'd1);
      cmp("rst_addr0",     32'(bus.ram0_rd_addr), 32'd0);
      run_to(40);
      cmp("rst_nrel0", 32'(rel0_q.size()), 32'd1);
      if (rel0_q.size() == 1) cmp("rst_rel0_cyc", 32'(rel0_q[0]), 32'd37);

      // ---- Filter drops one output: watchdog behaviour ----
      do_reset();
      drop_addr = 5;
      run_to(2);
      bus.wr_done0 = 1'b1;
`ifdef GS_LINE_SCHED_WDOG_EN
      run_to(27);
      cmp("wd_to_early", 32'(err_to),   32'd0);
      cmp("wd_busy",     32'(busy),     32'd1);
      run_to(28);
      cmp("wd_to_set",   32'(err_to),   32'd1);
      cmp("wd_rel0",     32'(bus.rel0), 32'd1);
      run_to(30);
      cmp("wd_idle",     32'(busy),     32'd0);
      cmp("wd_sticky",   32'(err_to),   32'd1);
`else
      run_to(40);
      cmp("nowd_busy",  32'(busy),           32'd1);
      cmp("nowd_norel", 32'(rel0_q.size()),  32'd0);
      cmp("nowd_to",    32'(err_to),         32'd0);
`endif
      drop_addr = -1;
      do_reset();

      cmp("start_rd_overlap", 32'(overlap), 32'd0);
      cmp("line_done_match",  32'(ld_bad),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/gs_line_sched.md
# gs_line_sched

Ping-pong line scheduler for the 5x5 Gaussian filter. Tracks which of the two line RAMs (bank 0 / bank 1) the upstream writer has filled. Reads the filled banks out in strict alternation into the filter's `ram0_*`/`ram1_*` inputs. Pulses the filter's `start` before each line, counts filtered pixels on `op_valid_out`, and releases each bank back to the writer once its line has fully drained.

## Interface
- `LINE_LEN`, 256: pixels per line; legal range 2..2^ADDR_W.
- `ADDR_W`, 8: RAM read-address width.
- `DRAIN_MAX`, 15: watchdog limit, in cycles, for DRAIN (used only with the macro).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_done0` / `wr_done1`  in  1  one-cycle pulse: the writer has finished filling bank 0 / bank 1.
- `op_valid_out`  in  1  filter output valid.
- `filt_start`  out  1  one-cycle clear pulse to the filter's `start`.
- `ram0_rd_en` / `ram1_rd_en`  out  1  bank read enable; RAM returns valid + data one cycle later.
- `ram0_rd_addr` / `ram1_rd_addr`  out  ADDR_W  bank read address.
- `rel0` / `rel1`  out  1  one-cycle pulse: the bank is free to be rewritten.
- `busy`  out  1  high in any state other than IDLE.
- `line_done`  out  1  one-cycle pulse at the end of each line.
- `err_ovf`  out  1  sticky; set by a `wr_done` on a bank that is already pending.
- `err_to`  out  1  sticky; set on watchdog expiry (macro only, otherwise tied to 0).

## Operation
- **Pending flags:** `pend[1:0]`, one per bank.
  - `wr_doneN` sets `pendN`.
  - Release of bank N clears `pendN`.
  - If set and clear hit in the same cycle, set wins.
  - `wr_doneN` while `pendN` is already 1 sets `err_ovf`; the flag stays set.
- **Bank pointer:** `cur`, reset to 0, toggles on every release. Only bank `cur` is ever served, so a pending non-current bank waits.
- **FSM states:** IDLE, CLR, READ, DRAIN, REL.
  - IDLE: go to CLR when `pend[cur]` is 1.
  - CLR: `filt_start`=1 for exactly one cycle. Address counter and output counter clear to 0. Go to READ.
  - READ: `ramcur_rd_en`=1 for exactly LINE_LEN consecutive cycles, with addresses 0..LINE_LEN-1 in increasing order. The other bank's rd_en stays 0. After address LINE_LEN-1, go to DRAIN.
  - DRAIN: count `op_valid_out` pulses, which are also counted during READ. When the count reaches LINE_LEN, go to REL.
  - REL: pulse `relcur` and `line_done`, clear `pend[cur]`, toggle `cur`, go to IDLE.
- **Output counter:** width ADDR_W+1; saturates at LINE_LEN. Any `op_valid_out` outside READ/DRAIN is ignored.
- `wr_done` pulses are accepted in every state.

## Timing
- **Reset values:** all outputs 0, `ram*_rd_addr`=0, `cur`=0, `pend`=0, state IDLE. Reset mid-line aborts immediately with no release pulse, and both error flags clear.
- **IDLE → CLR:** `wr_done0` at cycle t with IDLE and `cur`=0 gives `filt_start` at t+2 (t+1: `pend` registered; t+2: CLR).
- **Reads:** first `rd_en` at t+3, last at t+LINE_LEN+2.
- **Filter path:** RAM latency is 1 and the filter adds 5, so `op_valid_out` for address k arrives at rd_en(k)+6. The last output arrives at t+LINE_LEN+8.
- **Release:** REL is the cycle after the final counted output, so `rel`/`line_done` fire at t+LINE_LEN+9.
- **Back-to-back lines:** with the next bank already pending, the next `filt_start` comes at REL+2 (IDLE for one cycle). There is no overlap between lines, so the filter pipeline is never cleared while it holds live data.
- `filt_start` never coincides with any `rd_en`.

## Configuration
- Macro `GS_LINE_SCHED_WDOG_EN`.
  - **Defined:** a DRAIN cycle counter runs. If it reaches DRAIN_MAX before the output count completes, `err_to` is set and the FSM goes to REL (the bank is released anyway).
  - **Undefined:** DRAIN waits indefinitely, `err_to` is a constant 0, and the counter logic is absent.

## Structure
- Package `gs_line_sched_pkg` holds:
  - the state enum (IDLE/CLR/READ/DRAIN/REL);
  - `GS_RAM_LAT`=1;
  - `GS_FILT_LAT`=5;
  - `GS_KERNEL`=5.
- One sub-module, `gs_line_sched_wdog`: the DRAIN watchdog counter with inputs en/clr and output expire. It is instantiated only under the macro.

## Test plan
- **Single line:** reset, then `wr_done0` at cycle 10 with LINE_LEN=8 and a 6-cycle filter model → `filt_start` at 12; `ram0_rd_en` at 13..20 with addresses 0..7; `rel0`/`line_done` at 27; `cur`=1.
- **Strict ping-pong:** `wr_done1` before `wr_done0` → nothing happens until bank 0 is served. Then bank 0 runs, then bank 1, with `filt_start` at REL+2. `ram1_rd_en` is never high during bank 0's line.
- **Overflow:** `wr_done0` twice with no release between → `err_ovf`=1 and stays 1. A second `wr_done0` in the same cycle as `rel0` → `pend0` remains 1 and bank 0 is re-served after bank 1.
- **Reset mid-READ:** assert `rst` at read address 3 → the next cycle shows all outputs 0, IDLE, no `rel`. A new `wr_done0` restarts the line from address 0.
- **Watchdog (macro on, DRAIN_MAX=15):** filter model drops 1 output → `err_to` set 15 cycles into DRAIN, then `rel0`. With the macro off → the FSM stays in DRAIN and `busy`=1.
- **Spurious valid:** `op_valid_out` pulses while IDLE → counter unchanged; the next line still releases only after exactly LINE_LEN outputs.
